// File: rtl/sr_btn_conditioner.sv
// ============================================================================
// sr_btn_conditioner
//
// Turns two raw, bouncy push buttons (set, clear) into clean one-cycle s / r
// command pulses for a downstream SR flip-flop stage.
//
// Per channel: input register(s) -> stability-counter debounce -> rising
// commit sets a pending request flag. A small arbiter FSM (IDLE, PULSE,
// LOCKOUT) turns pending requests into pulses. Clear wins over set. s and r
// are never high together, and every pulse is followed by LOCKOUT_CYCLES
// forced idle cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a new synchronised level must persist (>= 1)
//   LOCKOUT_CYCLES   idle cycles forced after every pulse (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   set_btn  in   raw set button (asynchronous, may bounce)
//   clr_btn  in   raw clear button (asynchronous, may bounce)
//   s        out  registered one-cycle set command
//   r        out  registered one-cycle reset command
//   busy     out  registered, high whenever the arbiter is not in IDLE
//
// Build option:
//   SR_BTN_SYNC2_EN  when defined, each button passes through a 2-flop
//                    synchroniser instead of a single input register; this
//                    adds one cycle of latency to every path.
//
// Handshake: there is none; s / r are fire-and-forget strobes, each exactly
// one cycle wide, sampled by the downstream stage on the next rising edge.
// ============================================================================
module sr_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The lockout counter only ever holds LOCKOUT_CYCLES-1 down to 0.
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    // Channel 0 = set, channel 1 = clear.
    logic [1:0] raw_btn;
    logic [1:0] btn_sync;
    logic [1:0] rise;

    assign raw_btn = {clr_btn, set_btn};

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
`ifdef SR_BTN_SYNC2_EN
    logic [1:0] btn_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= raw_btn;
            btn_sync <= btn_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= raw_btn;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Debounce: a level different from the stable one must be seen for
    // DEBOUNCE_CYCLES consecutive cycles before it is committed. Any cycle
    // that agrees with the stable level restarts the count.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_db
        logic          stb;
        logic [CW-1:0] cnt;
        logic          commit;

        assign commit  = (btn_sync[g] != stb) && (cnt == CNT_MAX);
        // Only 0->1 commits become requests; releases are silent.
        assign rise[g] = commit && btn_sync[g];

        always_ff @(posedge clk) begin
            if (reset) begin
                stb <= 1'b0;
                cnt <= '0;
            end else if (btn_sync[g] == stb) begin
                cnt <= '0;
            end else if (commit) begin
                stb <= btn_sync[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending request flags. A fresh rise on the same edge the arbiter
    // consumes the old request keeps the flag set, so it is not lost.
    // ------------------------------------------------------------------
    logic pend_set;
    logic pend_clr;
    logic take_set;
    logic take_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
        end else begin
            pend_set <= (pend_set && !take_set) || rise[0];
            pend_clr <= (pend_clr && !take_clr) || rise[1];
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          s_nx;
    logic          r_nx;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_nx;

    always_comb begin
        state_nx = state;
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        take_set = 1'b0;
        take_clr = 1'b0;
        lock_nx  = lock_cnt;
        case (state)
            ST_IDLE: begin
                if (pend_clr) begin
                    r_nx     = 1'b1;
                    take_clr = 1'b1;
                    state_nx = ST_PULSE;
                end else if (pend_set) begin
                    s_nx     = 1'b1;
                    take_set = 1'b1;
                    state_nx = ST_PULSE;
                end
            end
            ST_PULSE: begin
                lock_nx  = LOCK_LOAD;
                state_nx = ST_LOCKOUT;
            end
            ST_LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    lock_nx = lock_cnt - LW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it rises together with s/r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_nx;
            s        <= s_nx;
            r        <= r_nx;
            busy     <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sr_btn_conditioner.sv
// ============================================================================
// tb_sr_btn_conditioner
//
// Bench for sr_btn_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=2.
// A reference model computes the expected s / r / busy from the behavioural
// rules: a level is accepted once the last D synchronised samples all
// differ from the stable level, and a pulse may be emitted at edge k only
// when k is at least L+2 edges after the previous pulse. A scenario table
// holds hand-derived pulse edges, a few hand-written sequences cover reset
// corner cases, and a long randomised run is checked cycle by cycle.
// ============================================================================
module tb_sr_btn_conditioner;

    localparam int D = 4;
    localparam int L = 2;
`ifdef SR_BTN_SYNC2_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic clk;
    logic reset;
    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic busy;

    int checks = 0;
    int errors = 0;

    sr_btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .set_btn(set_btn),
        .clr_btn(clr_btn),
        .s      (s),
        .r      (r),
        .busy   (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SR stage fed by the DUT outputs.
    logic sr_q = 1'b0;
    always @(posedge clk) begin
        if (reset)  sr_q <= 1'b0;
        else if (s) sr_q <= 1'b1;
        else if (r) sr_q <= 1'b0;
    end

    // ---------------- reference model ----------------
    int       m_k    = 0;      // edge counter
    int       m_base = 0;      // first edge after the latest reset
    int       m_last = -100;   // edge of the latest pulse
    bit [1:0] m_pipe0 = '0;
    bit [1:0] m_pipe1 = '0;
    bit [1:0] m_stb  = '0;
    bit [1:0] m_pend = '0;
    bit       m_hist [2][64];
    bit       m_s = 1'b0;
    bit       m_r = 1'b0;
    bit       m_busy = 1'b0;

    always @(posedge clk) begin : model
        bit [1:0] seen;
        bit [1:0] rise_m;
        bit [1:0] take_m;
        bit       all_diff;
        if (reset) begin
            m_pipe0 = '0;
            m_pipe1 = '0;
            m_stb   = '0;
            m_pend  = '0;
            m_s     = 1'b0;
            m_r     = 1'b0;
            m_busy  = 1'b0;
            m_last  = -100;
            m_base  = m_k + 1;
        end else begin
            seen   = (EXTRA == 1) ? m_pipe1 : m_pipe0;
            rise_m = '0;
            take_m = '0;
            for (int ch = 0; ch < 2; ch++) begin
                m_hist[ch][m_k % 64] = seen[ch];
                all_diff = (m_k - m_base + 1 >= D);
                if (all_diff) begin
                    for (int j = 0; j < D; j++) begin
                        if (m_hist[ch][(m_k - j) % 64] == m_stb[ch]) all_diff = 1'b0;
                    end
                end
                if (all_diff) begin
                    m_stb[ch] = ~m_stb[ch];
                    if (m_stb[ch]) rise_m[ch] = 1'b1;
                end
            end
            m_s = 1'b0;
            m_r = 1'b0;
            if (m_k - m_last >= L + 2) begin
                if (m_pend[1]) begin
                    m_r = 1'b1; take_m[1] = 1'b1; m_last = m_k;
                end else if (m_pend[0]) begin
                    m_s = 1'b1; take_m[0] = 1'b1; m_last = m_k;
                end
            end
            m_pend  = (m_pend & ~take_m) | rise_m;
            m_busy  = (m_k - m_last <= L);
            m_pipe1 = m_pipe0;
            m_pipe0 = {clr_btn, set_btn};
        end
        m_k = m_k + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_s", int'(s), int'(m_s));
        chk("model_r", int'(r), int'(m_r));
        chk("model_busy", int'(busy), int'(m_busy));
        chk("s_r_exclusive", int'(s & r), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic apply_reset(input int n);
        reset   = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        chk("reset_s", int'(s), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_busy", int'(busy), 0);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        string       name;
        logic [15:0] set_pat;   // bit i = level before edge i; bit 15 held after
        logic [15:0] clr_pat;
        int          s_cnt;
        int          s_first;   // edge of first s pulse, -1 if none
        int          r_cnt;
        int          r_first;
        int          busy_cyc;
        int          q_end;
    } scen_t;

    scen_t tbl [7];

    task automatic run_scenario(input scen_t sc);
        int          s_cnt = 0;
        int          r_cnt = 0;
        int          s_first = -1;
        int          r_first = -1;
        int          busy_cyc = 0;
        logic [15:0] sp;
        logic [15:0] cp;
        sp = sc.set_pat;
        cp = sc.clr_pat;
        apply_reset(2);
        for (int i = 0; i < 40; i++) begin
            set_btn = (i < 16) ? sp[i] : sp[15];
            clr_btn = (i < 16) ? cp[i] : cp[15];
            tick();
            if (s) begin if (s_cnt == 0) s_first = i; s_cnt++; end
            if (r) begin if (r_cnt == 0) r_first = i; r_cnt++; end
            if (busy) busy_cyc++;
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        chk({sc.name, "_s_count"}, s_cnt, sc.s_cnt);
        chk({sc.name, "_s_edge"}, s_first, (sc.s_first < 0) ? -1 : sc.s_first + EXTRA);
        chk({sc.name, "_r_count"}, r_cnt, sc.r_cnt);
        chk({sc.name, "_r_edge"}, r_first, (sc.r_first < 0) ? -1 : sc.r_first + EXTRA);
        chk({sc.name, "_busy_cycles"}, busy_cyc, sc.busy_cyc);
        chk({sc.name, "_sr_q"}, int'(sr_q), sc.q_end);
    endtask

    // ---------------- main sequence ----------------
    int rnd_hold [2];
    bit rnd_lvl  [2];

    initial begin
        reset   = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;

        tbl[0] = '{"clean_press",    16'hFFFF, 16'h0000, 1,  5, 0, -1, 3, 1};
        tbl[1] = '{"glitch",         16'h0007, 16'h0000, 0, -1, 0, -1, 0, 0};
        tbl[2] = '{"bounce_clr",     16'h0000, 16'hFFF5, 0, -1, 1,  9, 3, 0};
        tbl[3] = '{"simultaneous",   16'hFFFF, 16'hFFFF, 1,  9, 1,  5, 6, 1};
        tbl[4] = '{"set_then_clr",   16'hFFFF, 16'hFFFC, 1,  5, 1,  9, 6, 0};
        tbl[5] = '{"repress_ok",     16'hFF0F, 16'h0000, 2,  5, 0, -1, 6, 1};
        tbl[6] = '{"repress_early",  16'hFF8F, 16'h0000, 1,  5, 0, -1, 3, 1};

        for (int t = 0; t < 7; t++) run_scenario(tbl[t]);

        // Reset while s is high, buttons released during reset.
        begin
            int seen_s = 0;
            int later  = 0;
            apply_reset(2);
            set_btn = 1'b1;
            for (int n = 0; n < 20 && seen_s == 0; n++) begin
                tick();
                if (s) seen_s = 1;
            end
            chk("midrst_pulse_seen", seen_s, 1);
            reset   = 1'b1;
            set_btn = 1'b0;
            tick();
            chk("midrst_s_dropped", int'(s), 0);
            chk("midrst_busy_dropped", int'(busy), 0);
            reset = 1'b0;
            for (int n = 0; n < 20; n++) begin
                tick();
                if (s || r) later++;
            end
            chk("midrst_no_more_pulses", later, 0);
        end

        // Reset while s is high, button held through reset.
        begin
            int seen_s  = 0;
            int s_cnt   = 0;
            int s_first = -1;
            apply_reset(2);
            set_btn = 1'b1;
            for (int n = 0; n < 20 && seen_s == 0; n++) begin
                tick();
                if (s) seen_s = 1;
            end
            chk("heldrst_pulse_seen", seen_s, 1);
            reset = 1'b1;
            tick();
            chk("heldrst_s_dropped", int'(s), 0);
            reset = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (s) begin if (s_cnt == 0) s_first = i; s_cnt++; end
            end
            chk("heldrst_s_count", s_cnt, 1);
            chk("heldrst_s_edge", s_first, 5 + EXTRA);
            set_btn = 1'b0;
        end

        // Randomised hold lengths: short holds are glitches, long ones presses.
        apply_reset(2);
        rnd_hold[0] = 0;
        rnd_hold[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rnd_hold[ch] == 0) begin
                    rnd_lvl[ch]  = 1'($urandom_range(0, 1));
                    rnd_hold[ch] = $urandom_range(1, 12);
                end
                rnd_hold[ch]--;
            end
            set_btn = rnd_lvl[0];
            clr_btn = rnd_lvl[1];
            reset   = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
